hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 131 +++++++++++++
 tb/tb_hazard_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, undefined-instruction handling.
// Optional HAZARD_TRAP_HALT_EN: an undefined instruction traps the core in HALT until reset.
module hazard_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  ID_Rs1,
    input  logic [4:0]  ID_Rs2,
    input  logic [4:0]  EX_Rd,
    input  logic        EX_Mem_Rd,
    input  logic        Branch_Taken,
    input  logic        Jump,
    input  logic        undef_instr,
    output logic        NOP_Ins,
    output logic        CTRL_FLUSH,
    output logic        PC_Stall,
    output logic        IF_ID_Stall,
    output logic        Halted,
    output logic [15:0] Stall_Cnt
);

    // state | meaning
    // RUN   | normal issue, hazards and redirects detected
    // STALL | one bubble cycle after a load-use stall
    // FLUSH | squashing wrong-path fetches after a redirect
    // HALT  | trapped on undefined instruction, left only by reset
`ifdef HAZARD_TRAP_HALT_EN
    typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;
`else
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
`endif

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] flush_cnt;
    logic [1:0] flush_cnt_next;
    logic       hazard;
    logic       redirect;
    logic       nop_raw;
    logic       flush_raw;
    logic       stall_raw;
    logic       halted_raw;

    assign hazard   = EX_Mem_Rd && (EX_Rd != 5'd0) &&
                      ((EX_Rd == ID_Rs1) || (EX_Rd == ID_Rs2));
    assign redirect = Branch_Taken || Jump;

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        nop_raw        = 1'b0;
        flush_raw      = 1'b0;
        stall_raw      = 1'b0;
        halted_raw     = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    flush_raw      = 1'b1;
                    flush_cnt_next = FLUSH_LOAD;
                    state_next     = (FLUSH_LOAD != 2'd0) ? FLUSH : RUN;
                end else if (undef_instr) begin
`ifdef HAZARD_TRAP_HALT_EN
                    nop_raw    = 1'b1;
                    stall_raw  = 1'b1;
                    halted_raw = 1'b1;
                    state_next = HALT;
`else
                    nop_raw    = 1'b1;
`endif
                end else if (hazard) begin
                    nop_raw    = 1'b1;
                    stall_raw  = 1'b1;
                    state_next = STALL;
                end
            end
            STALL: begin
                // hazard and undef are not re-evaluated in the bubble cycle
                if (redirect) begin
                    flush_raw      = 1'b1;
                    flush_cnt_next = FLUSH_LOAD;
                    state_next     = (FLUSH_LOAD != 2'd0) ? FLUSH : RUN;
                end else begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                flush_raw      = 1'b1;
                flush_cnt_next = flush_cnt - 2'd1;
                if (flush_cnt <= 2'd1) begin
                    flush_cnt_next = 2'd0;
                    state_next     = RUN;
                end
            end
`ifdef HAZARD_TRAP_HALT_EN
            HALT: begin
                nop_raw    = 1'b1;
                stall_raw  = 1'b1;
                halted_raw = 1'b1;
            end
`endif
            default: begin
                state_next     = RUN;
                flush_cnt_next = 2'd0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held.
    assign NOP_Ins     = nop_raw    && !RST;
    assign CTRL_FLUSH  = flush_raw  && !RST;
    assign PC_Stall    = stall_raw  && !RST;
    assign IF_ID_Stall = stall_raw  && !RST;
    assign Halted      = halted_raw && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            flush_cnt <= 2'd0;
            Stall_Cnt <= 16'd0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            if (PC_Stall && (Stall_Cnt != 16'hFFFF))
                Stall_Cnt <= Stall_Cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver pushes model expectations, monitor pops and compares.
// Trap and saturation scenarios run only when HAZARD_TRAP_HALT_EN is defined.
module tb_hazard_unit;

    localparam int FC = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  ID_Rs1 = '0;
    logic [4:0]  ID_Rs2 = '0;
    logic [4:0]  EX_Rd = '0;
    logic        EX_Mem_Rd = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic        Jump = 1'b0;
    logic        undef_instr = 1'b0;
    logic        NOP_Ins;
    logic        CTRL_FLUSH;
    logic        PC_Stall;
    logic        IF_ID_Stall;
    logic        Halted;
    logic [15:0] Stall_Cnt;

    hazard_unit #(.FLUSH_CYCLES(FC)) dut (
        .CLK(CLK), .RST(RST), .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .EX_Rd(EX_Rd),
        .EX_Mem_Rd(EX_Mem_Rd), .Branch_Taken(Branch_Taken), .Jump(Jump),
        .undef_instr(undef_instr), .NOP_Ins(NOP_Ins), .CTRL_FLUSH(CTRL_FLUSH),
        .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .Halted(Halted),
        .Stall_Cnt(Stall_Cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [4:0]  bits;   // nop, flush, pc_stall, ifid_stall, halted
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // reference model: remaining flush cycles, pending bubble, trap flag, stall total
    int   m_flush_left = 0;
    bit   m_bubble = 0;
    bit   m_halt = 0;
    int   m_cnt = 0;

    task automatic step(input string name, input bit rst, input int rs1, input int rs2,
                        input int rd, input bit ld, input bit bt, input bit jp, input bit ud);
        exp_t e;
        bit   nop, fl, st, hl, load_use;
        @(posedge CLK);
        #1;
        RST = rst; ID_Rs1 = 5'(rs1); ID_Rs2 = 5'(rs2); EX_Rd = 5'(rd);
        EX_Mem_Rd = ld; Branch_Taken = bt; Jump = jp; undef_instr = ud;
        nop = 0; fl = 0; st = 0; hl = 0;
        load_use = ld && rd != 0 && (rd == rs1 || rd == rs2);
        e.cnt = 16'(m_cnt);
        if (rst) begin
            m_flush_left = 0; m_bubble = 0; m_halt = 0; m_cnt = 0;
        end else if (m_halt) begin
            nop = 1; st = 1; hl = 1;
        end else if (m_flush_left > 0) begin
            fl = 1; m_flush_left--;
        end else if (bt || jp) begin
            fl = 1; m_flush_left = FC - 1; m_bubble = 0;
        end else if (m_bubble) begin
            m_bubble = 0;
        end else if (ud) begin
`ifdef HAZARD_TRAP_HALT_EN
            m_halt = 1; nop = 1; st = 1; hl = 1;
`else
            nop = 1;
`endif
        end else if (load_use) begin
            nop = 1; st = 1; m_bubble = 1;
        end
        if (!rst && st) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        e.name = name;
        e.bits = {nop, fl, st, st, hl};
        q.push_back(e);
    endtask

    task automatic idle(input string name, input int n);
        for (int i = 0; i < n; i++) step(name, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e = q.pop_front();
            act = {NOP_Ins, CTRL_FLUSH, PC_Stall, IF_ID_Stall, Halted};
            total++;
            if (act !== e.bits || Stall_Cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s t=%0t got nop/fl/pcs/ifs/hlt=%b cnt=%0d want %b cnt=%0d",
                         e.name, $time, act, Stall_Cnt, e.bits, e.cnt);
            end
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        step("reset", 1, 5, 5, 5, 1, 1, 0, 1);
        idle("idle", 3);

        step("load_use", 0, 1, 5, 5, 1, 0, 0, 0);
        step("load_use_bubble", 0, 1, 5, 5, 1, 0, 0, 0);
        idle("load_use_after", 2);

        step("x0", 0, 0, 3, 0, 1, 0, 0, 0);
        step("mismatch", 0, 6, 6, 7, 1, 0, 0, 0);
        step("no_load", 0, 7, 6, 7, 0, 0, 0, 0);
        idle("idle", 2);

        step("jump", 0, 0, 0, 0, 0, 0, 1, 0);
        step("flush2_bt_ignored", 0, 0, 0, 0, 0, 1, 0, 0);
        idle("after_flush", 2);

        step("redirect_vs_hazard", 0, 3, 0, 3, 1, 1, 0, 0);
        step("flush_hazard_ignored", 0, 3, 0, 3, 1, 0, 0, 1);
        idle("after_rvh", 2);

        step("stall_then", 0, 4, 0, 4, 1, 0, 0, 0);
        step("bubble_redirect", 0, 4, 0, 4, 1, 0, 1, 0);
        idle("after_br", 3);

        step("mid_flush_rst_a", 0, 0, 0, 0, 0, 1, 0, 0);
        step("mid_flush_rst", 1, 0, 0, 0, 0, 0, 0, 0);
        idle("after_rst", 2);

        step("undef", 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef HAZARD_TRAP_HALT_EN
        idle("halt_hold", 100);
        step("halt_rst", 1, 0, 0, 0, 0, 0, 0, 0);
        idle("after_halt", 2);
`else
        idle("after_undef", 2);
        step("undef_vs_hazard", 0, 2, 0, 2, 1, 0, 0, 1);
        idle("after_uvh", 2);
`endif

        for (int i = 0; i < 2000; i++) begin
            step("random", ($urandom_range(0, 99) == 0), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 24) == 0));
        end

`ifdef HAZARD_TRAP_HALT_EN
        step("sat_rst", 1, 0, 0, 0, 0, 0, 0, 0);
        step("sat_trap", 0, 0, 0, 0, 0, 0, 0, 1);
        idle("saturate", 70000);
        step("sat_rst_end", 1, 0, 0, 0, 0, 0, 0, 0);
`endif

        @(negedge CLK);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
